// File: rtl/lb_addr_sequencer_pkg.sv
// Shared state encoding and default widths for the line-buffer address sequencer.
`default_nettype none

package lb_addr_sequencer_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;

  localparam int LB_ADDR_W = 9;
  localparam int RUN_LEN_W = 5;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_FIN  = ST_FIN
  } seq_state_e;

endpackage

`default_nettype wire

// File: rtl/lb_addr_sequencer_counter.sv
// Synchronous loadable up/down counter with clock enable and terminal count.
`default_nettype none

module lb_updown_counter #(
  parameter int W = 9
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         CE,
  input  logic         LOAD,
  input  logic         DIR,
  input  logic [W-1:0] D,
  output logic [W-1:0] Q,
  output logic         TC
);

  logic [W-1:0] count;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      count <= '0;
    end else if (LOAD) begin
      count <= D;
    end else if (CE) begin
      count <= DIR ? (count - W'(1)) : (count + W'(1));
    end
  end

  assign Q  = count;
  // Terminal count is the last value before wrapping in the current direction.
  assign TC = DIR ? (count == '0) : (&count);

endmodule

`default_nettype wire

// File: rtl/lb_addr_sequencer.sv
// Line-buffer write-address sequencer: loads a start X and run length, then
// steps the address up or down once per pixel enable, strobing WE per pixel.
`default_nettype none

module lb_addr_sequencer
  import lb_addr_sequencer_pkg::*;
#(
  parameter int ADDR_W = LB_ADDR_W,
  parameter int LEN_W  = RUN_LEN_W
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              CE,
  input  logic              START,
  input  logic [ADDR_W-1:0] X_START,
  input  logic [LEN_W-1:0]  RUN_LEN,
  input  logic              FLIP,
  input  logic              ABORT,
  output logic [ADDR_W-1:0] ADDR,
  output logic              WE,
  output logic              BUSY,
  output logic              DONE,
  output logic              TC
);

  seq_state_e        state, state_nxt;
  logic [LEN_W-1:0]  remaining;
  logic              dir;
  logic              load;
  logic              step;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    case (state)
      S_IDLE: begin
        if (START) begin
          load      = 1'b1;
          state_nxt = (RUN_LEN != '0) ? S_RUN : S_FIN;
        end
      end
      S_RUN: begin
        // Abort wins over stepping; a coincident write still happens via WE.
        if (ABORT) begin
          state_nxt = S_IDLE;
        end else if (CE) begin
          step = 1'b1;
          if (remaining == LEN_W'(1)) begin
            state_nxt = S_FIN;
          end
        end
      end
      S_FIN: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      remaining <= '0;
      dir       <= 1'b0;
    end else if (load) begin
      remaining <= RUN_LEN;
      dir       <= FLIP;
    end else if (step) begin
      remaining <= remaining - LEN_W'(1);
    end
  end

  lb_updown_counter #(
    .W(ADDR_W)
  ) u_addr_cnt (
    .CLK  (CLK),
    .RESET(RESET),
    .CE   (step),
    .LOAD (load),
    .DIR  (dir),
    .D    (X_START),
    .Q    (ADDR),
    .TC   (TC)
  );

  assign BUSY = (state == S_RUN);
  assign WE   = (state == S_RUN) && CE;
  assign DONE = (state == S_FIN);

endmodule

`default_nettype wire

// File: tb/tb_lb_addr_sequencer.sv
// Scoreboard bench: driver pushes expected writes/done pulses, monitor pops and compares.
`default_nettype none

module tb_lb_addr_sequencer;

  logic       CLK = 1'b0;
  logic       RESET, CE, START, FLIP, ABORT;
  logic [8:0] X_START;
  logic [4:0] RUN_LEN;
  logic [8:0] ADDR;
  logic       WE, BUSY, DONE, TC;

  int total = 0;
  int bad   = 0;

  logic [8:0] exp_addr_q[$];
  bit         exp_tc_q[$];
  int         exp_done_q[$];
  int         run_id = 0;

  lb_addr_sequencer #(.ADDR_W(9), .LEN_W(5)) dut (
    .CLK(CLK), .RESET(RESET), .CE(CE), .START(START), .X_START(X_START),
    .RUN_LEN(RUN_LEN), .FLIP(FLIP), .ABORT(ABORT), .ADDR(ADDR), .WE(WE),
    .BUSY(BUSY), .DONE(DONE), .TC(TC)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Monitor: every write strobe and done pulse must match the next scoreboard entry.
  always @(negedge CLK) begin
    if (!RESET) begin
      if (WE) begin
        if (exp_addr_q.size() == 0) begin
          chk("unexpected_we", 1, 0);
        end else begin
          logic [8:0] ea;
          bit         et;
          ea = exp_addr_q.pop_front();
          et = exp_tc_q.pop_front();
          chk("we_addr", int'(ADDR), int'(ea));
          chk("we_tc", int'(TC), int'(et));
        end
      end
      if (DONE) begin
        if (exp_done_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          void'(exp_done_q.pop_front());
        end
      end
    end
  end

  // Reference model: a run of n pixels writes x, x+/-1, ... modulo 512.
  task automatic model_push(input logic [8:0] x, input int n, input bit flip, input bit done);
    logic [8:0] a;
    for (int k = 0; k < n; k++) begin
      a = flip ? (x - 9'(k)) : (x + 9'(k));
      exp_addr_q.push_back(a);
      exp_tc_q.push_back(flip ? (a == 9'h000) : (a == 9'h1FF));
    end
    if (done) exp_done_q.push_back(run_id);
    run_id++;
  endtask

  // ce_mode: 0 = always on, 1 = alternating 1,0,..., 2 = random.
  // abort_at: pixel number (1-based) on which ABORT is raised with CE=1; 0 = none.
  task automatic do_run(input logic [8:0] x, input int len, input bit flip,
                        input int ce_mode, input int abort_at, input bit noise_start);
    int n;
    int issued;
    int cyc;
    bit ce;
    n = (abort_at != 0) ? abort_at : len;
    model_push(x, n, flip, abort_at == 0);
    START = 1'b1; X_START = x; RUN_LEN = 5'(len); FLIP = flip;
    CE = 1'($urandom_range(0, 1)); ABORT = 1'b0;
    tick();
    START = 1'b0; X_START = 9'($urandom); RUN_LEN = 5'($urandom); FLIP = 1'($urandom);
    issued = 0;
    cyc = 0;
    while (issued < n) begin
      case (ce_mode)
        0:       ce = 1'b1;
        1:       ce = (cyc % 2 == 0);
        default: ce = ($urandom_range(0, 2) != 0);
      endcase
      CE    = ce;
      ABORT = ce && (abort_at != 0) && (issued + 1 == abort_at);
      START = noise_start && ($urandom_range(0, 2) == 0);
      X_START = 9'($urandom);
      RUN_LEN = 5'($urandom_range(1, 31));
      if (ce) issued++;
      cyc++;
      @(negedge CLK);
      chk("busy_in_run", int'(BUSY), 1);
      tick();
      if (cyc > 400) begin
        chk("run_cycle_budget", cyc, 400);
        break;
      end
    end
    ABORT = 1'b0;
    CE    = 1'($urandom_range(0, 1));
    START = noise_start;
    @(negedge CLK);
    chk("done_after_run", int'(DONE), int'(abort_at == 0));
    chk("busy_after_run", int'(BUSY), 0);
    START = 1'b0;
    if (abort_at == 0) tick();
  endtask

  initial begin
    RESET = 1'b1; CE = 1'b1; START = 1'b1; FLIP = 1'b0; ABORT = 1'b0;
    X_START = 9'h0AA; RUN_LEN = 5'd7;
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      chk("rst_addr", int'(ADDR), 0);
      chk("rst_we", int'(WE), 0);
      chk("rst_busy", int'(BUSY), 0);
      chk("rst_done", int'(DONE), 0);
    end
    @(posedge CLK); #1;
    RESET = 1'b0; START = 1'b0;
    @(negedge CLK);
    chk("post_rst_busy", int'(BUSY), 0);
    tick();

    do_run(9'h010, 4, 1'b0, 0, 0, 1'b0);
    do_run(9'h001, 3, 1'b1, 0, 0, 1'b0);
    do_run(9'h1FE, 3, 1'b0, 0, 0, 1'b0);
    do_run(9'h040, 3, 1'b0, 1, 0, 1'b0);
    do_run(9'h055, 0, 1'b0, 0, 0, 1'b0);
    do_run(9'h100, 5, 1'b1, 0, 0, 1'b1);
    do_run(9'h020, 8, 1'b0, 0, 3, 1'b0);
    do_run(9'h0F0, 2, 1'b1, 0, 0, 1'b0);

    for (int r = 0; r < 40; r++) begin
      int len;
      int ab;
      len = $urandom_range(0, 31);
      ab  = (len > 0 && $urandom_range(0, 4) == 0) ? $urandom_range(1, len) : 0;
      do_run(9'($urandom), len, 1'($urandom), $urandom_range(0, 2), ab, 1'($urandom));
      repeat ($urandom_range(0, 2)) tick();
    end

    repeat (3) tick();
    chk("sb_writes_left", exp_addr_q.size(), 0);
    chk("sb_done_left", exp_done_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/lb_addr_sequencer.md
Name: lb_addr_sequencer

Overview:
- Line-buffer write-address sequencer for the sprite/tile pixel pipeline.
- Loads a start X position and a run length, then steps the address up (normal) or down (flipped) once per pixel clock-enable. Emits a write strobe for each pixel and a done pulse when the run ends.
- Sits directly upstream of the line-buffer RAM. It replaces the discrete cascaded up/down loadable 4-bit counter chain with a single synchronous, clock-enabled block.

Parameters:
- ADDR_W, 9, line-buffer address width; addresses wrap modulo 2^ADDR_W.
- LEN_W, 5, run-length width; the maximum run is 2^LEN_W - 1 pixels.

Ports:
- CLK  in  1  system clock; the only clock.
- RESET  in  1  synchronous, active-high reset.
- CE  in  1  pixel clock-enable; all address and count stepping is qualified by CE.
- START  in  1  run request; sampled on any CLK edge while IDLE.
- X_START  in  ADDR_W  first write address; captured on START acceptance.
- RUN_LEN  in  LEN_W  number of pixels to write; captured on START acceptance.
- FLIP  in  1  direction; 0 = increment, 1 = decrement. Captured on START acceptance.
- ABORT  in  1  cancels an active run.
- ADDR  out  ADDR_W  current write address.
- WE  out  1  line-buffer write strobe.
- BUSY  out  1  high while in RUN.
- DONE  out  1  one-CLK pulse when a run completes normally.
- TC  out  1  terminal count: ADDR == all-ones when incrementing, ADDR == 0 when decrementing.

Behaviour:
- Clocking: one clock, CLK. RESET is synchronous and active-high; it has priority over every other input.
- Reset values: state = IDLE, ADDR = 0, remaining = 0, dir = 0, BUSY = 0, WE = 0, DONE = 0.
- States: IDLE, RUN, FIN.
- IDLE:
  - START = 1 latches ADDR <= X_START, remaining <= RUN_LEN, dir <= FLIP.
  - If RUN_LEN != 0, go to RUN.
  - If RUN_LEN == 0, go to FIN; no writes are issued.
  - CE is not needed to accept START.
- RUN:
  - WE = CE (combinational, only in RUN). ADDR presents the address for the current write.
  - On a CLK edge with CE = 1: ADDR <= ADDR + 1 if dir = 0, ADDR - 1 if dir = 1, modulo 2^ADDR_W; remaining <= remaining - 1.
  - If remaining == 1 on a CE edge, go to FIN.
  - CE = 0 holds all state; no write occurs.
- FIN: DONE = 1 for exactly one CLK, then go to IDLE. START in FIN is ignored.
- ABORT in RUN: go to IDLE at the next edge. No DONE pulse. If CE is also high on that edge, that write still occurs (WE is combinational); ADDR and remaining are not stepped. ABORT in IDLE or FIN has no effect.
- START in RUN or FIN: ignored, not queued. The producer retries after DONE or once BUSY is low.
- BUSY = (state == RUN). A new run can be accepted on the CLK after DONE.
- TC is combinational from ADDR and dir. It is valid in all states and is informational only; it does not stop the run. The run wraps through the address boundary.
- Latency:
  - START edge to first WE: WE is valid in the following cycle if CE = 1.
  - A run of N pixels with CE held high: WE is high for N cycles, then DONE follows on the next cycle.
- Inputs X_START, RUN_LEN and FLIP may change freely after acceptance.

Decomposition:
- Shared package: state encoding constants (ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_FIN = 2'd2) and default widths (LB_ADDR_W = 9, RUN_LEN_W = 5).
- One natural sub-module: lb_updown_counter. It is a synchronous loadable up/down counter of width ADDR_W with CE, a load, and a terminal-count output. It is instantiated for ADDR. The remaining counter is a plain down counter inline.

Test Plan:
- Reset: RESET high for 2 CLK with START = 1 -> ADDR = 0, WE = 0, BUSY = 0, DONE = 0. No run starts until the CLK after RESET falls.
- Increment run: X_START = 0x010, RUN_LEN = 4, FLIP = 0, CE = 1 constantly -> WE high for 4 cycles at ADDR 0x010, 0x011, 0x012, 0x013; DONE pulses once on the next cycle; BUSY is low afterwards.
- Flipped wrap: X_START = 0x001, RUN_LEN = 3, FLIP = 1 -> writes at 0x001, 0x000, 0x1FF. TC is high while ADDR = 0x000. DONE is single-cycle.
- CE gating: RUN_LEN = 3, CE toggling 1,0,1,0,1 -> exactly 3 WE strobes at consecutive addresses; ADDR is held during CE = 0 cycles; DONE after the third write.
- Zero length and ignored start: RUN_LEN = 0 -> no WE, DONE one cycle after START. Then START pulsed mid-run of length 5 -> still exactly 5 writes and no second run.
- Abort: RUN_LEN = 8, ABORT asserted during the 3rd write cycle (CE = 1) -> 3 writes total, IDLE next cycle, no DONE, BUSY low. A new START is accepted the following cycle.
